// File: rtl/fc2_pkg.sv
// Shared constants, FSM state type and output saturation for the fc2 classifier.
package fc2_pkg;

    localparam int DW    = 16;
    localparam int FRAC  = 10;
    localparam int ACC_W = 40;
    localparam int N_IN  = 128;
    localparam int N_OUT = 10;

    localparam logic [10:0] W_BASE = 11'h000;
    localparam logic [10:0] B_BASE = 11'h500;

    typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, CMP, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    // Clamp an already-rescaled accumulator value to Q5.10.
    function automatic logic signed [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7FFF;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return signed'(v[DW-1:0]);
    endfunction

endpackage

// File: rtl/fc2_argmax_if.sv
// Start/activation inputs, ROM port and result outputs of the fc2 classifier.
interface fc2_argmax_if;
    import fc2_pkg::*;

    logic                 iStart;
    logic [N_IN*DW-1:0]   iAct;
    logic [10:0]          oRomAddr;
    logic [DW-1:0]        iRomData;
    logic                 oDone;
    logic [3:0]           oDigit;
    logic [DW-1:0]        oScore;

    modport master (
        input  iStart, iAct, iRomData,
        output oRomAddr, oDone, oDigit, oScore
    );

    modport slave (
        output iStart, iAct, iRomData,
        input  oRomAddr, oDone, oDigit, oScore
    );

endinterface

// File: rtl/fc2_argmax_mac_unit.sv
// Serial 40-bit signed accumulator: bias load (rescaled to Q10.20) or 16x16 MAC.
module mac_unit
    import fc2_pkg::*;
(
    input  logic                    clk,
    input  logic                    iRst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic signed [DW-1:0]    din,
    input  logic signed [DW-1:0]    act,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0] prod;

    assign prod = din * act;

    always_ff @(posedge clk) begin
        if (iRst || clear)
            acc <= '0;
        else if (load)
            acc <= {{(ACC_W-DW-FRAC){din[DW-1]}}, din, {FRAC{1'b0}}};
        else if (acc_en)
            acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end

endmodule

// File: rtl/fc2_argmax.sv
// FC2 layer + argmax: 10 serial dot products of 128 latched activations against ROM weights.
//   state | meaning
//   IDLE  | waiting for start; one armed cycle after start before class 0
//   BIAS  | present bias address for class k
//   MAC   | present weight addresses j=0..127, accumulate previous ROM word
//   DRAIN | accumulate the last weight still in flight
//   CMP   | saturate score, update best, step k
//   DONE  | result held on outputs
module fc2_argmax
    import fc2_pkg::*;
(
    input  logic         clk,
    input  logic         iRst,
    fc2_argmax_if.master bus
);

    state_t                  state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic [6:0]              j_q, j_d;
    logic                    armed_q, armed_d;
    logic [10:0]             addr_q, addr_d;
    logic [N_IN*DW-1:0]      act_q;
    logic signed [DW-1:0]    best_q, best_d;
    logic [3:0]              best_idx_q, best_idx_d;
    logic                    done_q, done_d;
    logic [3:0]              digit_q, digit_d;
    logic signed [DW-1:0]    score_q, score_d;

    logic                    act_ld, mac_clear, mac_load, mac_en;
    logic [6:0]              act_idx;
    logic signed [DW-1:0]    act_sel;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    score_s;
    logic                    take;
    logic signed [DW-1:0]    win_score;
    logic [3:0]              win_idx;

    function automatic logic [10:0] w_addr(input logic [3:0] k, input logic [6:0] j);
        return W_BASE + {k, 7'd0} + {4'd0, j};
    endfunction

    function automatic logic [10:0] b_addr(input logic [3:0] k);
        return B_BASE + {7'd0, k};
    endfunction

    // ROM data lags the address by one cycle, so MAC cycle j pairs with act[j-1].
    assign act_idx = (state_q == DRAIN) ? 7'd127 : (j_q - 7'd1);
    assign act_sel = signed'(act_q[act_idx*DW +: DW]);

    mac_unit u_mac (
        .clk    (clk),
        .iRst   (iRst),
        .clear  (mac_clear),
        .load   (mac_load),
        .acc_en (mac_en),
        .din    (signed'(bus.iRomData)),
        .act    (act_sel),
        .acc    (acc)
    );

    assign score_s   = sat16(acc >>> FRAC);
    assign take      = (k_q == 4'd0) || (score_s > best_q);
    assign win_score = take ? score_s : best_q;
    assign win_idx   = take ? k_q : best_idx_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        j_d        = j_q;
        armed_d    = armed_q;
        addr_d     = '0;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        done_d     = done_q;
        digit_d    = digit_q;
        score_d    = score_q;
        act_ld     = 1'b0;
        mac_clear  = 1'b0;
        mac_load   = 1'b0;
        mac_en     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == IDLE && armed_q) begin
                    state_d = BIAS;
                    armed_d = 1'b0;
                    j_d     = '0;
                    addr_d  = b_addr(k_q);
                end else if (bus.iStart) begin
                    act_ld    = 1'b1;
                    mac_clear = 1'b1;
                    done_d    = 1'b0;
                    k_d       = '0;
                    j_d       = '0;
                    armed_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            BIAS: begin
                state_d = MAC;
                j_d     = '0;
                addr_d  = w_addr(k_q, 7'd0);
            end
            MAC: begin
                if (j_q == 7'd0)
                    mac_load = 1'b1;
                else
                    mac_en = 1'b1;
                if (j_q != 7'd127) begin
                    j_d    = j_q + 7'd1;
                    addr_d = w_addr(k_q, j_q + 7'd1);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mac_en  = 1'b1;
                state_d = CMP;
            end
            CMP: begin
                best_d     = win_score;
                best_idx_d = win_idx;
                if (k_q < 4'(N_OUT - 1)) begin
                    k_d     = k_q + 4'd1;
                    j_d     = '0;
                    state_d = BIAS;
                    addr_d  = b_addr(k_q + 4'd1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    digit_d = win_idx;
                    score_d = win_score;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            j_q        <= '0;
            armed_q    <= 1'b0;
            addr_q     <= '0;
            act_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            done_q     <= 1'b0;
            digit_q    <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            score_q    <= score_d;
            if (act_ld)
                act_q <= bus.iAct;
        end
    end

    assign bus.oRomAddr = addr_q;
    assign bus.oDone    = done_q;
    assign bus.oDigit   = digit_q;
    assign bus.oScore   = score_q;

endmodule

// File: tb/tb_fc2_argmax.sv
// Scoreboard bench for fc2_argmax: directed ROM/activation images, result and latency checks.
module tb_fc2_argmax;
    import fc2_pkg::*;

    typedef struct {
        logic [3:0]  digit;
        logic [15:0] score;
        int          e0;
    } exp_t;

    localparam int LAT = 1311;

    logic clk = 1'b0;
    logic iRst;

    fc2_argmax_if bus();

    fc2_argmax dut (
        .clk  (clk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:2047];
    always @(posedge clk) bus.iRomData <= rom[bus.oRomAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every rising oDone is matched against the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (bus.oDone && !done_prev) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got oDone=1 want no result pending (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("digit", 32'(bus.oDigit), 32'(e.digit));
                check("score", 32'(bus.oScore), 32'(e.score));
                check("done_latency", 32'(cyc - e.e0), 32'(LAT));
            end
        end
        done_prev = bus.oDone;
    end

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        bus.iAct = '0;
    endtask

    task automatic set_act(input int j, input logic [15:0] v);
        bus.iAct[j*16 +: 16] = v;
    endtask

    task automatic setup_ramp();
        clear_mem();
        set_act(3, 16'h0800);
        for (int k = 0; k < 10; k++) rom[int'(W_BASE) + k*128 + 3] = 16'(k * 16'h0200);
    endtask

    task automatic setup_bias_tie(input bit bump4);
        clear_mem();
        for (int j = 0; j < 128; j++) set_act(j, 16'h0400);
        for (int k = 0; k < 10; k++) rom[int'(B_BASE) + k] = 16'hFC00;
        if (bump4) rom[int'(B_BASE) + 4] = 16'hFE00;
    endtask

    // Issues a start; the activation bus is scrambled right after the sampling edge.
    task automatic start_run(input bit push, input logic [3:0] dg, input logic [15:0] sc);
        exp_t e;
        @(negedge clk);
        bus.iStart = 1'b1;
        e.digit = dg;
        e.score = sc;
        e.e0    = cyc + 1;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        bus.iAct   = {N_IN{16'h5A5A}};
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d results pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int t, p, kk, trace_err;
        logic [10:0] want_a, first_got, first_want;

        iRst       = 1'b1;
        bus.iStart = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        iRst = 1'b0;
        check("rst_done",  32'(bus.oDone),    32'd0);
        check("rst_digit", 32'(bus.oDigit),   32'd0);
        check("rst_score", 32'(bus.oScore),   32'd0);
        check("rst_addr",  32'(bus.oRomAddr), 32'd0);

        // Positive saturation, with a full address trace
        clear_mem();
        for (int j = 0; j < 128; j++) set_act(j, 16'h0400);
        for (int j = 0; j < 128; j++) rom[int'(W_BASE) + 7*128 + j] = 16'h0400;
        start_run(1'b1, 4'd7, 16'h7FFF);
        e0 = cyc;
        trace_err  = 0;
        first_got  = '0;
        first_want = '0;
        for (int n = 0; n < LAT; n++) begin
            @(negedge clk);
            t = cyc - e0;
            if (t >= 1) begin
                kk = (t - 1) / 131;
                p  = (t - 1) % 131;
                if (p <= 128) begin
                    want_a = (p == 0) ? 11'(int'(B_BASE) + kk)
                                      : 11'(int'(W_BASE) + kk*128 + p - 1);
                    if (bus.oRomAddr !== want_a) begin
                        if (trace_err == 0) begin
                            first_got  = bus.oRomAddr;
                            first_want = want_a;
                        end
                        trace_err++;
                    end
                end
            end
        end
        total++;
        if (trace_err != 0) begin
            bad++;
            $display("FAIL addr_trace: got %0d wrong cycles, first got=0x%0h want=0x%0h",
                     trace_err, first_got, first_want);
        end
        wait_done();

        setup_ramp();
        start_run(1'b1, 4'd9, 16'h2400);
        wait_done();

        setup_bias_tie(1'b0);
        start_run(1'b1, 4'd0, 16'hFC00);
        wait_done();

        setup_bias_tie(1'b1);
        start_run(1'b1, 4'd4, 16'hFE00);
        wait_done();

        // Negative saturation: every class ties at the floor
        clear_mem();
        for (int j = 0; j < 128; j++) set_act(j, 16'h7FFF);
        for (int i = 0; i < 1280; i++) rom[int'(W_BASE) + i] = 16'h8000;
        start_run(1'b1, 4'd0, 16'h8000);
        wait_done();

        // Start pulse while busy must be ignored
        setup_ramp();
        start_run(1'b1, 4'd9, 16'h2400);
        repeat (199) @(negedge clk);
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        wait_done();

        // Reset in the middle of a run, then a clean restart
        setup_ramp();
        start_run(1'b0, 4'd0, 16'h0000);
        repeat (499) @(negedge clk);
        iRst = 1'b1;
        @(posedge clk);
        #1;
        iRst = 1'b0;
        @(negedge clk);
        check("midrst_done",  32'(bus.oDone),    32'd0);
        check("midrst_digit", 32'(bus.oDigit),   32'd0);
        check("midrst_score", 32'(bus.oScore),   32'd0);
        check("midrst_addr",  32'(bus.oRomAddr), 32'd0);

        setup_ramp();
        start_run(1'b1, 4'd9, 16'h2400);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
